// File: rtl/thermal_trip_monitor.sv
// Thermal trip monitor: debounced overheat flag with hysteresis between a hot
// and a cool threshold, plus a saturating count of confirmed overheat trips.
module thermal_trip_monitor #(
    parameter int unsigned TEMP_W      = 8,
    parameter int unsigned HOT_THRESH  = 85,
    parameter int unsigned COOL_THRESH = 70,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned TRIP_W      = 8
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp,
    input  logic              clr_trips,
    output logic              cpu_overheated,
    output logic              warn,
    output logic [TRIP_W-1:0] trip_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_COOL      = 2'd0,
        ST_HEAT_PEND = 2'd1,
        ST_HOT       = 2'd2,
        ST_COOL_PEND = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               streak_done;
    logic               trip_inc;
    logic               is_hot;
    logic               is_cool;
    logic               overheated_d;
    logic               warn_d;
    logic [TRIP_W-1:0]  trip_d;

    // Sample classification; equality with a threshold counts toward that side.
    assign is_hot      = temp >= TEMP_W'(HOT_THRESH);
    assign is_cool     = temp <= TEMP_W'(COOL_THRESH);
    assign cnt_inc     = cnt + CNT_W'(1);
    assign streak_done = cnt_inc == CNT_W'(DEBOUNCE);

    // State and streak counter registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= ST_COOL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and streak logic; cycles without a sample hold everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        trip_inc  = 1'b0;
        if (temp_valid) begin
            unique case (state)
                ST_COOL: begin
                    if (is_hot) begin
                        if (DEBOUNCE <= 1) begin
                            state_nxt = ST_HOT;
                            cnt_nxt   = '0;
                            trip_inc  = 1'b1;
                        end else begin
                            state_nxt = ST_HEAT_PEND;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ST_HEAT_PEND: begin
                    if (is_hot) begin
                        if (streak_done) begin
                            state_nxt = ST_HOT;
                            cnt_nxt   = '0;
                            trip_inc  = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        state_nxt = ST_COOL;
                        cnt_nxt   = '0;
                    end
                end
                ST_HOT: begin
                    if (is_cool) begin
                        if (DEBOUNCE <= 1) begin
                            state_nxt = ST_COOL;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = ST_COOL_PEND;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ST_COOL_PEND: begin
                    if (is_cool) begin
                        if (streak_done) begin
                            state_nxt = ST_COOL;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        state_nxt = ST_HOT;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = ST_COOL;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the flags land on the accepting edge.
    always_comb begin
        overheated_d = (state_nxt == ST_HOT) || (state_nxt == ST_COOL_PEND);
        warn_d       = (state_nxt == ST_HEAT_PEND);
        trip_d       = trip_count;
        if (clr_trips) begin
            trip_d = trip_inc ? TRIP_W'(1) : '0;
        end else if (trip_inc && (trip_count != {TRIP_W{1'b1}})) begin
            trip_d = trip_count + TRIP_W'(1);
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cpu_overheated <= 1'b0;
            warn           <= 1'b0;
            trip_count     <= '0;
        end else begin
            cpu_overheated <= overheated_d;
            warn           <= warn_d;
            trip_count     <= trip_d;
        end
    end

endmodule

// File: tb/tb_thermal_trip_monitor.sv
// Bench for thermal_trip_monitor: directed scenarios plus random samples,
// checked against a flag/streak reference model.
module tb_thermal_trip_monitor;

    localparam int unsigned TEMP_W = 8;
    localparam int unsigned TRIP_W = 8;
    localparam int HOT  = 85;
    localparam int COOL = 70;
    localparam int DB   = 4;

    logic              clk;
    logic              areset_n;
    logic              temp_valid;
    logic [TEMP_W-1:0] temp;
    logic              clr_trips;
    logic              cpu_overheated;
    logic              warn;
    logic [TRIP_W-1:0] trip_count;

    int checks = 0;
    int errors = 0;

    // Reference model: overheat flag, length of the current streak toward
    // flipping it, and the trip tally.
    bit m_flag;
    int m_streak;
    int m_trips;

    thermal_trip_monitor #(
        .TEMP_W(TEMP_W), .HOT_THRESH(HOT), .COOL_THRESH(COOL),
        .DEBOUNCE(DB), .TRIP_W(TRIP_W)
    ) dut (
        .clk(clk), .areset_n(areset_n), .temp_valid(temp_valid), .temp(temp),
        .clr_trips(clr_trips), .cpu_overheated(cpu_overheated), .warn(warn),
        .trip_count(trip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flag = 0; m_streak = 0; m_trips = 0;
    endtask

    task automatic model_sample(input bit v, input int t, input bit clr);
        bit tripped = 0;
        if (v) begin
            if (!m_flag) begin
                m_streak = (t >= HOT) ? m_streak + 1 : 0;
                if (m_streak == DB) begin
                    m_flag = 1; m_streak = 0; tripped = 1;
                end
            end else begin
                m_streak = (t <= COOL) ? m_streak + 1 : 0;
                if (m_streak == DB) begin
                    m_flag = 0; m_streak = 0;
                end
            end
        end
        if (clr) m_trips = tripped ? 1 : 0;
        else if (tripped && m_trips < 255) m_trips = m_trips + 1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ovh"},  int'(cpu_overheated), int'(m_flag));
        check({tag, ".warn"}, int'(warn), int'(!m_flag && m_streak > 0));
        check({tag, ".trip"}, int'(trip_count), m_trips);
    endtask

    task automatic step(input bit v, input int t, input bit clr, input string tag);
        @(negedge clk);
        temp_valid = v;
        temp       = TEMP_W'(t);
        clr_trips  = clr;
        @(posedge clk);
        #1;
        model_sample(v, t, clr);
        temp_valid = 1'b0;
        clr_trips  = 1'b0;
        check_model(tag);
    endtask

    task automatic quiet_step(input int t);
        @(negedge clk);
        temp_valid = 1'b1;
        temp       = TEMP_W'(t);
        clr_trips  = 1'b0;
        @(posedge clk);
        #1;
        model_sample(1'b1, t, 1'b0);
        temp_valid = 1'b0;
    endtask

    initial begin
        int trips_before;
        areset_n   = 1'b0;
        temp_valid = 1'b0;
        temp       = '0;
        clr_trips  = 1'b0;
        model_reset();
        #23;
        check("rst.ovh", int'(cpu_overheated), 0);
        check("rst.warn", int'(warn), 0);
        check("rst.trip", int'(trip_count), 0);
        @(negedge clk);
        areset_n = 1'b1;

        // Four hot samples confirm an overheat.
        for (int i = 0; i < 3; i++) begin
            step(1, 90, 0, "heat");
            check("heat.warn_pend", int'(warn), 1);
        end
        step(1, 90, 0, "heat4");
        check("heat4.ovh", int'(cpu_overheated), 1);
        check("heat4.warn", int'(warn), 0);
        check("heat4.trip", int'(trip_count), 1);
        for (int i = 0; i < 4; i++) step(1, 70, 0, "rel");
        check("rel.ovh", int'(cpu_overheated), 0);

        // A single non-hot reading breaks the streak.
        step(1, 90, 0, "brk"); step(1, 90, 0, "brk"); step(1, 90, 0, "brk");
        step(1, 84, 0, "brk84");
        check("brk84.warn", int'(warn), 0);
        check("brk84.ovh", int'(cpu_overheated), 0);
        step(1, 90, 0, "brk90");
        check("brk90.warn", int'(warn), 1);
        for (int i = 0; i < 3; i++) step(1, 90, 0, "reheat");
        check("reheat.ovh", int'(cpu_overheated), 1);

        // In-band readings hold the flag; four cool readings release it.
        for (int i = 0; i < 10; i++) step(1, (i % 3 == 0) ? 75 : (i % 3 == 1) ? 80 : 71, 0, "band");
        check("band.ovh", int'(cpu_overheated), 1);
        for (int i = 0; i < 4; i++) step(1, 70, 0, "cool");
        check("cool.ovh", int'(cpu_overheated), 0);

        // Aborted release returns to the hot side without counting a trip.
        for (int i = 0; i < 4; i++) step(1, 90, 0, "hot2");
        trips_before = int'(trip_count);
        step(1, 70, 0, "abort"); step(1, 70, 0, "abort"); step(1, 72, 0, "abort72");
        check("abort.ovh", int'(cpu_overheated), 1);
        check("abort.trip", int'(trip_count), trips_before);
        for (int i = 0; i < 3; i++) step(1, 70, 0, "abort_rel");
        check("abort_rel3.ovh", int'(cpu_overheated), 1);
        step(1, 70, 0, "abort_rel4");
        check("abort_rel4.ovh", int'(cpu_overheated), 0);

        // Idle gaps do not break a streak.
        step(1, 90, 0, "gap"); step(1, 90, 0, "gap");
        for (int i = 0; i < 5; i++) step(0, 0, 0, "gap_idle");
        check("gap_idle.warn", int'(warn), 1);
        step(1, 90, 0, "gap"); step(1, 90, 0, "gap4");
        check("gap4.ovh", int'(cpu_overheated), 1);
        for (int i = 0; i < 4; i++) step(1, 70, 0, "gap_rel");

        // Clear coinciding with a trip leaves exactly one.
        step(1, 90, 0, "clr"); step(1, 90, 0, "clr"); step(1, 90, 0, "clr");
        step(1, 90, 1, "clr_trip");
        check("clr_trip.trip", int'(trip_count), 1);
        for (int i = 0; i < 4; i++) step(1, 70, 0, "clr_rel");
        step(0, 0, 1, "clr_only");
        check("clr_only.trip", int'(trip_count), 0);

        // Drive 256 trips; the counter must saturate.
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 4; i++) quiet_step(90);
            for (int i = 0; i < 4; i++) quiet_step(70);
        end
        check_model("sat");
        check("sat.trip", int'(trip_count), 255);

        // Random samples concentrated around both thresholds.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(60, 100)),
                 ($urandom_range(0, 40) == 0), "rand");
        end

        // Asynchronous reset in the middle of a hot streak.
        for (int i = 0; i < 4; i++) step(1, 70, 0, "pre_rst");
        step(1, 90, 0, "mid"); step(1, 90, 0, "mid");
        check("mid.warn", int'(warn), 1);
        @(negedge clk);
        #2;
        areset_n = 1'b0;
        #1;
        model_reset();
        check("arst.ovh", int'(cpu_overheated), 0);
        check("arst.warn", int'(warn), 0);
        check("arst.trip", int'(trip_count), 0);
        @(negedge clk);
        areset_n = 1'b1;
        step(1, 90, 0, "post_rst");
        check("post_rst.warn", int'(warn), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
